// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and helpers for the APB-to-register-bus bridge.
// Provides the FSM state encoding and the address window test.
package apb_reg_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    // The offset is taken modulo 2**aw, so addresses below base wrap high and miss.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] size,
                                       input int          aw);
        logic [63:0] mask;
        logic [63:0] off;
        mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
        off  = (addr - base) & mask;
        return off < size;
    endfunction

endpackage

// File: rtl/apb_reg_bridge.sv
// APB4 completer that turns each APB transfer into one valid/ready register request.
// Out-of-window accesses and unresponsive slaves complete with PSLVERR so APB never stalls.
module apb_reg_bridge
    import apb_reg_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [63:0]           WINDOW_SIZE    = 64'h1000,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o,
    output logic                    reg_valid_o,
    output logic                    reg_write_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    input  logic                    reg_ready_i,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_error_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e                  state_q;
    state_e                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    access;
    logic                    hit;
    logic                    timeout_hit;
    logic [ADDR_WIDTH-1:0]   offset;

    assign access      = psel_i & penable_i;
    assign offset      = paddr_i - BASE_ADDR;
    assign hit         = in_window(64'(paddr_i), 64'(BASE_ADDR), WINDOW_SIZE, ADDR_WIDTH);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = hit ? REQ : RESP;
            REQ:     if (reg_ready_i || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // valid/ready are registered decodes of the next state so they are glitch-free
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pready_o    <= 1'b0;
            prdata_o    <= '0;
            pslverr_o   <= 1'b0;
            reg_valid_o <= 1'b0;
            reg_write_o <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wstrb_o <= '0;
        end else begin
            state_q     <= state_d;
            pready_o    <= (state_d == RESP);
            reg_valid_o <= (state_d == REQ);
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    prdata_o  <= '0;
                    pslverr_o <= 1'b0;
                    if (access) begin
                        if (hit) begin
                            reg_write_o <= pwrite_i;
                            reg_addr_o  <= offset;
                            reg_wdata_o <= pwdata_i;
                            reg_wstrb_o <= pwrite_i ? pstrb_i : {STRB_W{1'b0}};
                        end else begin
                            pslverr_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (reg_ready_i) begin
                        cnt_q     <= '0;
                        prdata_o  <= reg_write_o ? '0 : reg_rdata_i;
                        pslverr_o <= reg_error_i;
                    end else if (timeout_hit) begin
                        cnt_q     <= '0;
                        prdata_o  <= '0;
                        pslverr_o <= 1'b1;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q     <= '0;
                    prdata_o  <= '0;
                    pslverr_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed self-checking bench for apb_reg_bridge.
// Instance a: base 0, timeout 256; instance b: base 0x4000, timeout 4.
module tb_apb_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite, use_b;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        reg_ready, reg_error;
    logic [31:0] reg_rdata;

    logic        pready_a, pslverr_a, valid_a, write_a;
    logic [31:0] prdata_a, addr_a, wdata_a;
    logic [3:0]  wstrb_a;
    logic        pready_b, pslverr_b, valid_b, write_b;
    logic [31:0] prdata_b, addr_b, wdata_b;
    logic [3:0]  wstrb_b;

    logic        m_pready, m_pslverr, m_valid, m_write;
    logic [31:0] m_prdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    int tests = 0;
    int fails = 0;

    // results of the most recent apb_xfer
    int          r_vcnt, r_rdy_at;
    logic [31:0] r_prdata, r_addr, r_wdata;
    logic        r_err, r_write;
    logic [3:0]  r_wstrb;
    bit          r_stable;

    always #5 clk = ~clk;

    apb_reg_bridge #(.TIMEOUT_CYCLES(256)) dut_a (
        .clk_i(clk), .rst_i(rst), .psel_i(psel & ~use_b), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready_a), .prdata_o(prdata_a), .pslverr_o(pslverr_a),
        .reg_valid_o(valid_a), .reg_write_o(write_a), .reg_addr_o(addr_a),
        .reg_wdata_o(wdata_a), .reg_wstrb_o(wstrb_a), .reg_ready_i(reg_ready),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error));

    apb_reg_bridge #(.BASE_ADDR(32'h4000), .TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .psel_i(psel & use_b), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready_b), .prdata_o(prdata_b), .pslverr_o(pslverr_b),
        .reg_valid_o(valid_b), .reg_write_o(write_b), .reg_addr_o(addr_b),
        .reg_wdata_o(wdata_b), .reg_wstrb_o(wstrb_b), .reg_ready_i(reg_ready),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error));

    assign m_pready  = use_b ? pready_b  : pready_a;
    assign m_pslverr = use_b ? pslverr_b : pslverr_a;
    assign m_valid   = use_b ? valid_b   : valid_a;
    assign m_write   = use_b ? write_b   : write_a;
    assign m_prdata  = use_b ? prdata_b  : prdata_a;
    assign m_addr    = use_b ? addr_b    : addr_a;
    assign m_wdata   = use_b ? wdata_b   : wdata_a;
    assign m_wstrb   = use_b ? wstrb_b   : wstrb_a;

    // APB master plus register-slave model: ready rises once valid has been high 'delay' cycles.
    // r_rdy_at counts edges from the access edge until pready is seen; -1 means it never came.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int delay, input logic err,
                            input logic [31:0] rdata, input bit drop_early);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        reg_ready = 1'b0; reg_error = err; reg_rdata = rdata;
        r_vcnt = 0; r_rdy_at = -1; r_stable = 1'b1; r_prdata = '0; r_err = 1'b0;
        r_addr = '0; r_wdata = '0; r_wstrb = '0; r_write = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        for (int n = 1; n <= 300 && r_rdy_at < 0; n++) begin
            @(posedge clk); #1;
            if (drop_early) begin psel = 1'b0; penable = 1'b0; end
            if (m_valid) begin
                if (r_vcnt == 0) begin
                    r_addr = m_addr; r_wdata = m_wdata; r_wstrb = m_wstrb; r_write = m_write;
                end else if (r_addr !== m_addr || r_wdata !== m_wdata ||
                             r_wstrb !== m_wstrb || r_write !== m_write) begin
                    r_stable = 1'b0;
                end
                r_vcnt++;
            end
            if (m_pready) begin r_rdy_at = n; r_prdata = m_prdata; r_err = m_pslverr; end
            reg_ready = m_valid && (r_vcnt > delay);
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; reg_ready = 1'b0; reg_error = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
            paddr = $urandom_range(0, 255); pwdata = $urandom; pstrb = 4'($urandom);
            reg_ready = 1'($urandom); reg_error = 1'($urandom); reg_rdata = $urandom;
            use_b = 1'($urandom);
            @(posedge clk); #1;
            tests++;
            if ({pready_a, pslverr_a, prdata_a, valid_a, write_a, addr_a, wdata_a, wstrb_a} !== '0) begin
                fails++; $display("FAIL reset_a: outputs %h required 0",
                    {pready_a, pslverr_a, prdata_a, valid_a, write_a, addr_a, wdata_a, wstrb_a});
            end
            tests++;
            if ({pready_b, pslverr_b, prdata_b, valid_b, write_b, addr_b, wdata_b, wstrb_b} !== '0) begin
                fails++; $display("FAIL reset_b: outputs %h required 0",
                    {pready_b, pslverr_b, prdata_b, valid_b, write_b, addr_b, wdata_b, wstrb_b});
            end
        end
        psel = 1'b0; penable = 1'b0; reg_ready = 1'b0; reg_error = 1'b0; use_b = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({valid_a, valid_b, pready_a, pready_b} !== 4'b0) begin
                fails++; $display("FAIL idle_after_reset: valid/pready %b required 0000",
                    {valid_a, valid_b, pready_a, pready_b});
            end
        end
    endtask

    task automatic test_write();
        use_b = 1'b0;
        apb_xfer(1'b1, 32'h10, 32'hCAFEF00D, 4'b0101, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        tests++; if (r_vcnt != 1) begin fails++; $display("FAIL wr_valid_cycles: got %0d required 1", r_vcnt); end
        tests++; if (r_rdy_at != 2) begin fails++; $display("FAIL wr_latency: got %0d required 2", r_rdy_at); end
        tests++; if (r_addr !== 32'h10) begin fails++; $display("FAIL wr_addr: got %h required 00000010", r_addr); end
        tests++; if (r_wdata !== 32'hCAFEF00D) begin fails++; $display("FAIL wr_wdata: got %h required cafef00d", r_wdata); end
        tests++; if (r_wstrb !== 4'b0101) begin fails++; $display("FAIL wr_wstrb: got %b required 0101", r_wstrb); end
        tests++; if (r_write !== 1'b1) begin fails++; $display("FAIL wr_write: got %b required 1", r_write); end
        tests++; if ({r_err, r_prdata} !== 33'h0) begin fails++; $display("FAIL wr_resp: err %b data %h required 0/0", r_err, r_prdata); end
        tests++; if ({m_pready, m_pslverr, m_valid} !== 3'b0) begin fails++; $display("FAIL wr_pulse_end: pready/err/valid %b required 000", {m_pready, m_pslverr, m_valid}); end
    endtask

    task automatic test_read_wait();
        use_b = 1'b0;
        apb_xfer(1'b0, 32'h20, 32'h0, 4'b1111, 5, 1'b0, 32'h12345678, 1'b0);
        tests++; if (r_vcnt != 6) begin fails++; $display("FAIL rd_valid_cycles: got %0d required 6", r_vcnt); end
        tests++; if (r_rdy_at != 7) begin fails++; $display("FAIL rd_latency: got %0d required 7", r_rdy_at); end
        tests++; if (r_prdata !== 32'h12345678) begin fails++; $display("FAIL rd_data: got %h required 12345678", r_prdata); end
        tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL rd_err: got %b required 0", r_err); end
        tests++; if ({r_write, r_wstrb, r_addr} !== {1'b0, 4'b0, 32'h20}) begin fails++; $display("FAIL rd_fields: write %b strb %b addr %h required 0/0000/00000020", r_write, r_wstrb, r_addr); end
        tests++; if (!r_stable) begin fails++; $display("FAIL rd_stable: got changed required stable"); end
        tests++; if (m_prdata !== 32'h0) begin fails++; $display("FAIL rd_prdata_idle: got %h required 0", m_prdata); end
        // slave error on a read still returns the read data
        apb_xfer(1'b0, 32'h44, 32'h0, 4'b0, 0, 1'b1, 32'hA5A5A5A5, 1'b0);
        tests++; if ({r_err, r_prdata} !== {1'b1, 32'hA5A5A5A5}) begin fails++; $display("FAIL rd_slave_err: err %b data %h required 1/a5a5a5a5", r_err, r_prdata); end
    endtask

    task automatic test_window();
        use_b = 1'b0;
        apb_xfer(1'b0, 32'h2000, 32'h0, 4'b0, 0, 1'b0, 32'h11111111, 1'b0);
        tests++; if (r_vcnt != 0) begin fails++; $display("FAIL oow_valid: got %0d required 0", r_vcnt); end
        tests++; if (r_rdy_at != 1) begin fails++; $display("FAIL oow_latency: got %0d required 1", r_rdy_at); end
        tests++; if ({r_err, r_prdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL oow_resp: err %b data %h required 1/0", r_err, r_prdata); end
        tests++; if (m_pslverr !== 1'b0) begin fails++; $display("FAIL oow_err_idle: got %b required 0", m_pslverr); end
        apb_xfer(1'b0, 32'hFFC, 32'h0, 4'b0, 0, 1'b0, 32'h0BADCAFE, 1'b0);
        tests++; if ({r_vcnt, r_err, r_prdata} !== {32'd1, 1'b0, 32'h0BADCAFE}) begin fails++; $display("FAIL win_top_in: valid %0d err %b data %h required 1/0/0badcafe", r_vcnt, r_err, r_prdata); end
        apb_xfer(1'b1, 32'h1000, 32'h5, 4'hF, 0, 1'b0, 32'h0, 1'b0);
        tests++; if ({r_vcnt, r_err} !== {32'd0, 1'b1}) begin fails++; $display("FAIL win_edge_out: valid %0d err %b required 0/1", r_vcnt, r_err); end
        use_b = 1'b1;
        apb_xfer(1'b0, 32'h3FFC, 32'h0, 4'b0, 0, 1'b0, 32'h0, 1'b0);
        tests++; if ({r_vcnt, r_err} !== {32'd0, 1'b1}) begin fails++; $display("FAIL win_below_base: valid %0d err %b required 0/1", r_vcnt, r_err); end
        use_b = 1'b0;
    endtask

    task automatic test_timeout();
        use_b = 1'b1;
        apb_xfer(1'b0, 32'h4008, 32'h0, 4'b0, 1000, 1'b0, 32'h77777777, 1'b0);
        tests++; if (r_vcnt != 4) begin fails++; $display("FAIL to_valid_cycles: got %0d required 4", r_vcnt); end
        tests++; if (r_rdy_at != 5) begin fails++; $display("FAIL to_latency: got %0d required 5", r_rdy_at); end
        tests++; if ({r_err, r_prdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL to_resp: err %b data %h required 1/0", r_err, r_prdata); end
        tests++; if (r_addr !== 32'h8) begin fails++; $display("FAIL to_offset: got %h required 00000008", r_addr); end
        apb_xfer(1'b1, 32'h4010, 32'h99, 4'b0011, 1, 1'b1, 32'h0, 1'b0);
        tests++; if ({r_vcnt, r_rdy_at} !== {32'd2, 32'd3}) begin fails++; $display("FAIL err_timing: valid %0d latency %0d required 2/3", r_vcnt, r_rdy_at); end
        tests++; if ({r_err, r_prdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL err_resp: err %b data %h required 1/0", r_err, r_prdata); end
        use_b = 1'b0;
    endtask

    task automatic test_setup_only();
        int seen;
        seen = 0;
        use_b = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid_a || pready_a) seen++;
        end
        psel = 1'b0;
        tests++; if (seen != 0) begin fails++; $display("FAIL setup_only: active cycles %0d required 0", seen); end
    endtask

    task automatic test_protocol_violation();
        use_b = 1'b0;
        apb_xfer(1'b0, 32'h30, 32'h0, 4'b0, 3, 1'b0, 32'h600DF00D, 1'b1);
        tests++; if ({r_vcnt, r_rdy_at} !== {32'd4, 32'd5}) begin fails++; $display("FAIL drop_psel_timing: valid %0d latency %0d required 4/5", r_vcnt, r_rdy_at); end
        tests++; if (r_prdata !== 32'h600DF00D) begin fails++; $display("FAIL drop_psel_data: got %h required 600df00d", r_prdata); end
    endtask

    task automatic test_back_to_back();
        use_b = 1'b0;
        apb_xfer(1'b1, 32'h40, 32'h01020304, 4'b1000, 0, 1'b0, 32'h0, 1'b0);
        tests++; if ({r_rdy_at, r_addr, r_wstrb} !== {32'd2, 32'h40, 4'b1000}) begin fails++; $display("FAIL b2b_first: latency %0d addr %h strb %b required 2/40/1000", r_rdy_at, r_addr, r_wstrb); end
        apb_xfer(1'b0, 32'h48, 32'h0, 4'b1111, 2, 1'b0, 32'hFEEDFACE, 1'b0);
        tests++; if ({r_rdy_at, r_addr, r_prdata} !== {32'd4, 32'h48, 32'hFEEDFACE}) begin fails++; $display("FAIL b2b_second: latency %0d addr %h data %h required 4/48/feedface", r_rdy_at, r_addr, r_prdata); end
    endtask

    task automatic test_async_reset();
        use_b = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h34; reg_ready = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL arst_pre_valid: got %b required 1", valid_a); end
        #2 rst = 1'b1;
        #1;
        tests++; if ({valid_a, pready_a, addr_a} !== {1'b0, 1'b0, 32'h0}) begin fails++; $display("FAIL arst_immediate: valid %b pready %b addr %h required 0/0/0", valid_a, pready_a, addr_a); end
        @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h38, 32'h0, 4'b0, 0, 1'b0, 32'h13579BDF, 1'b0);
        tests++; if ({r_rdy_at, r_err, r_prdata} !== {32'd2, 1'b0, 32'h13579BDF}) begin fails++; $display("FAIL arst_recover: latency %0d err %b data %h required 2/0/13579bdf", r_rdy_at, r_err, r_prdata); end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; use_b = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = '0;
        test_reset();
        test_write();
        test_read_wait();
        test_window();
        test_timeout();
        test_setup_only();
        test_protocol_violation();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
